// File: rtl/image_stream_tx_if.sv
// Byte-stream and pixel-memory port bundle for image_stream_tx.
// master = streamer side, slave = memory/transmitter side.
interface image_stream_tx_if #(
    parameter int PIXEL_W = 12,
    parameter int ADDR_W  = 7
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIXEL_W-1:0] mem_rdata;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output mem_addr,
        output tx_data,
        output tx_valid,
        input  mem_rdata,
        input  tx_ready
    );

    modport slave (
        input  mem_addr,
        input  tx_data,
        input  tx_valid,
        output mem_rdata,
        output tx_ready
    );
endinterface

// File: rtl/image_stream_tx.sv
// Frame streamer: walks pixel memory row-major (decimated) and emits SYNC, mode, pixel bytes (+XOR checksum if IMAGE_STREAM_TX_CHECKSUM_EN).
// Latency: SYNC valid the cycle after start; two idle cycles (fetch + read) before each pixel's first byte.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; abort only lands on an empty or handshaken byte slot.
module image_stream_tx #(
    parameter int         PIXEL_W   = 12,
    parameter int         IMAGE_W   = 10,
    parameter int         IMAGE_H   = 10,
    parameter int         ADDR_W    = $clog2(IMAGE_W * IMAGE_H),
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        decim,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    image_stream_tx_if.master bus
);
    localparam int         BPB       = (PIXEL_W + 7) / 8;
    localparam int         SH_W      = BPB * 8;
    localparam int         CNT_W     = 12;
    localparam int         BASE_W    = 22;
    localparam logic [1:0] LAST_BYTE = 2'(BPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_SYNC,
        S_HDR_MODE,
        S_FETCH,
        S_WAIT_RD,
        S_SEND
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        dec_q, dec_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [1:0]        byte_q, byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              tx_valid;
    logic [7:0]        tx_data;
    logic [7:0]        mode_byte;
    logic              hs;
    logic [CNT_W-1:0]  step;
    logic [CNT_W-1:0]  col_nxt;
    logic [CNT_W-1:0]  row_nxt;
    logic [BASE_W-1:0] row_step;
    logic              col_more;
    logic              more;

    assign mode_byte = {6'b0, dec_q};
    assign step      = CNT_W'(1) << dec_q;
    assign row_step  = BASE_W'(IMAGE_W) << dec_q;
    assign col_nxt   = col_q + step;
    assign row_nxt   = row_q + step;
    assign col_more  = col_nxt < CNT_W'(IMAGE_W);
    assign more      = col_more || (row_nxt < CNT_W'(IMAGE_H));
    assign hs        = tx_valid && bus.tx_ready;

    // Outputs decode straight from registered state so they cannot change during a stall.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_HDR_SYNC: begin tx_valid = 1'b1; tx_data = SYNC_BYTE;            end
            S_HDR_MODE: begin tx_valid = 1'b1; tx_data = mode_byte;            end
            S_SEND:     begin tx_valid = 1'b1; tx_data = shift_q[SH_W-1 -: 8]; end
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
            S_CKSUM:    begin tx_valid = 1'b1; tx_data = csum_q;               end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_HDR_SYNC;
                    dec_d   = (decim == 2'd3) ? 2'd2 : decim;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                end
            end
            S_HDR_SYNC: if (hs) state_d = S_HDR_MODE;
            S_HDR_MODE: begin
                if (hs) begin
                    state_d = S_FETCH;
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
                    csum_d  = mode_byte;
`endif
                end
            end
            S_FETCH: state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                state_d = S_SEND;
                shift_d = SH_W'(bus.mem_rdata);
                byte_d  = 2'd0;
            end
            S_SEND: begin
                if (hs) begin
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
                    csum_d  = csum_q ^ tx_data;
`endif
                    shift_d = shift_q << 8;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == LAST_BYTE) begin
                        if (more) begin
                            state_d = S_FETCH;
                            if (col_more) begin
                                col_d = col_nxt;
                            end else begin
                                col_d  = '0;
                                row_d  = row_nxt;
                                base_d = base_q + row_step;
                            end
                        end else begin
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
                            state_d = S_CKSUM;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
            S_CKSUM: begin
                if (hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort never cuts a byte the receiver has already seen as valid.
        if (state_q != S_IDLE && abort && (!tx_valid || hs)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dec_q   <= 2'd0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            byte_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= 8'h00;
        else     csum_q <= csum_d;
    end
`endif

    assign bus.mem_addr = base_q[ADDR_W-1:0] + ADDR_W'(col_q);
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_image_stream_tx.sv
// Randomized bench for image_stream_tx: frame model built from the row/column walk rules, per-cycle output checks.
`timescale 1ns/1ps
module tb_image_stream_tx;
    localparam int W   = 10;
    localparam int H   = 10;
    localparam int BPB = 2;
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic [1:0] decim0 = 2'd0;
    logic       busy0, done0;
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [1:0] decim1 = 2'd0;
    logic       busy1, done1;

    image_stream_tx_if #(.PIXEL_W(12), .ADDR_W(7)) bus0 ();
    image_stream_tx_if #(.PIXEL_W(16), .ADDR_W(4)) bus1 ();

    image_stream_tx dut0 (
        .clk(clk), .rst(rst), .start(start0), .decim(decim0), .abort(abort0),
        .busy(busy0), .done(done0), .bus(bus0)
    );
    image_stream_tx #(.PIXEL_W(16), .IMAGE_W(5), .IMAGE_H(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .decim(decim1), .abort(abort1),
        .busy(busy1), .done(done1), .bus(bus1)
    );

    always #5 clk = ~clk;

    logic [11:0] mem0 [0:127];
    logic [15:0] mem1 [0:15];
    always @(posedge clk) bus0.mem_rdata <= mem0[bus0.mem_addr];
    always @(posedge clk) bus1.mem_rdata <= mem1[bus1.mem_addr];

    int checks = 0;
    int fails  = 0;
    int popped = 0;
    int done_cnt = 0;
    int done1_cnt = 0;
    int rmode = 0;       // 0: ready high, 1: ready random 30%, 2: ready low
    logic [7:0] exp_q[$];
    logic [7:0] got1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference frame: header, then pixels visited on the decimated grid, MSB first.
    function automatic void build_frame(input logic [1:0] d);
        int s;
        logic [7:0]  md, ck;
        logic [15:0] p;
        md = (d == 2'd3) ? 8'd2 : {6'd0, d};
        s  = 1 << md;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(md);
        ck = md;
        for (int r = 0; r < H; r += s)
            for (int c = 0; c < W; c += s) begin
                p = {4'h0, mem0[r*W + c]};
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
                ck = ck ^ p[15:8] ^ p[7:0];
            end
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
        popped   = 0;
        done_cnt = 0;
    endfunction

    initial begin
        bus0.tx_ready = 1'b1;
        bus1.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)      bus0.tx_ready = 1'b1;
            else if (rmode == 1) bus0.tx_ready = ($urandom_range(0, 99) < 30);
            else                 bus0.tx_ready = 1'b0;
        end
    end

    initial begin : monitor
        logic       prev_stall, want_v, exp_done;
        logic [7:0] prev_d, e;
        int         gap;
        prev_stall = 1'b0; want_v = 1'b0; exp_done = 1'b0; prev_d = 8'h00; gap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0; want_v = 1'b0; exp_done = 1'b0; gap = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", bus0.tx_valid, 1);
                    chk("stall_data", bus0.tx_data, prev_d);
                end
                if (gap > 0) begin
                    chk("bubble_low", bus0.tx_valid, 0);
                    gap--;
                    if (gap == 0) want_v = 1'b1;
                end else if (want_v) begin
                    chk("bubble_end", bus0.tx_valid, 1);
                    want_v = 1'b0;
                end
                chk("done", done0, exp_done);
                if (done0) done_cnt++;
                exp_done = 1'b0;
                if (bus0.tx_valid && bus0.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL extra_byte actual=%02h required=none", bus0.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", popped), bus0.tx_data, e);
                        popped++;
                        if (exp_q.size() == 0)
                            exp_done = 1'b1;
                        else if ((popped == 2 || (popped > 2 && (popped - 2) % BPB == 0)) && exp_q.size() > CK)
                            gap = 2;
                    end
                end
                prev_stall = bus0.tx_valid && !bus0.tx_ready;
                prev_d     = bus0.tx_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus1.tx_valid && bus1.tx_ready) got1.push_back(bus1.tx_data);
                if (done1) done1_cnt++;
            end
        end
    end

    task automatic pulse_start(input logic [1:0] d);
        @(posedge clk); #2;
        decim0 = d;
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        decim0 = 2'($urandom);
        chk("start_busy", busy0, 1);
        chk("start_valid", bus0.tx_valid, 1);
        chk("start_sync", bus0.tx_data, 8'hA5);
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #2;
            if (!busy0 && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("frame_end");
        @(posedge clk); #2;
        chk("left_bytes", exp_q.size(), 0);
        chk("done_count", done_cnt, 1);
    endtask

    task automatic run_frame(input logic [1:0] d, input int mode, input bit midstart);
        rmode = mode;
        build_frame(d);
        pulse_start(d);
        if (midstart) begin
            repeat (40) @(posedge clk);
            #2;
            start0 = 1'b1;
            decim0 = ~d;
            @(posedge clk); #2;
            start0 = 1'b0;
        end
        wait_end();
    endtask

    logic [7:0] exp1 [0:13] = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'hBE, 8'hE2, 8'hBE,
                                8'hE4, 8'hBE, 8'hEA, 8'hBE, 8'hEC, 8'hBE, 8'hEE};

    initial begin
        bit ok;
        for (int i = 0; i < 128; i++) mem0[i] = (i < 50) ? 12'h00F : 12'hF00;
        for (int i = 0; i < 16; i++)  mem1[i] = 16'hBEE0 + 16'(i);
        mem1[0] = 16'hBEEF;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", bus0.tx_valid, 0);
        chk("rst_data", bus0.tx_data, 0);
        chk("rst_addr", bus0.mem_addr, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst = 1'b0;

        build_frame(2'd0);
        chk("model_len_d0", exp_q.size(), 202 + CK);
        chk("model_b3", exp_q[3], 8'h0F);
        chk("model_b102", exp_q[102], 8'h0F);
        chk("model_b103", exp_q[103], 8'h00);
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
        chk("model_cksum", exp_q[202], 8'h00);
`endif
        run_frame(2'd0, 0, 1'b0);

        build_frame(2'd1);
        chk("model_len_d1", exp_q.size(), 52 + CK);
        chk("model_mode_d1", exp_q[1], 8'h01);
        chk("model_b31_d1", exp_q[31], 8'h0F);
        chk("model_b32_d1", exp_q[32], 8'h0F);
        chk("model_b33_d1", exp_q[33], 8'h00);
        run_frame(2'd1, 0, 1'b0);

        build_frame(2'd3);
        chk("model_len_d3", exp_q.size(), 20 + CK);
        chk("model_mode_d3", exp_q[1], 8'h02);
        run_frame(2'd3, 0, 1'b0);

        // start together with abort in idle must not open a frame
        @(posedge clk); #2;
        start0 = 1'b1; abort0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_busy", busy0, 0);
        chk("start_abort_valid", bus0.tx_valid, 0);

        for (int i = 0; i < 128; i++) mem0[i] = 12'($urandom);
        run_frame(2'($urandom_range(0, 2)), 1, 1'b1);
        run_frame(2'd0, 1, 1'b0);
        run_frame(2'($urandom_range(1, 3)), 1, 1'b0);

        // abort while the first byte of pixel 10 is stalled
        rmode = 0;
        build_frame(2'd0);
        pulse_start(2'd0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (popped >= 22) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("abort_reach_px10");
        rmode = 2;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (bus0.tx_valid && !bus0.tx_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("abort_stall");
        abort0 = 1'b1;
        @(posedge clk); #2;
        chk("abort_stall_busy", busy0, 1);
        rmode = 0;
        @(posedge clk); #2;
        chk("abort_pending_busy", busy0, 1);
        @(posedge clk); #2;
        chk("abort_busy", busy0, 0);
        chk("abort_valid", bus0.tx_valid, 0);
        chk("abort_done", done0, 0);
        chk("abort_popped", popped, 23);
        abort0 = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        run_frame(2'd0, 1, 1'b0);

        // reset in the middle of a frame
        rmode = 0;
        build_frame(2'd0);
        pulse_start(2'd0);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", bus0.tx_valid, 0);
        chk("mrst_data", bus0.tx_data, 0);
        chk("mrst_addr", bus0.mem_addr, 0);
        chk("mrst_busy", busy0, 0);
        chk("mrst_done", done0, 0);
        exp_q.delete();
        popped = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        run_frame(2'($urandom), 1, 1'b0);

        // small 5x3 image with 16-bit pixels
        @(posedge clk); #2;
        decim1 = 2'd1;
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (!busy1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("small_end");
        @(posedge clk); #2;
        chk("small_len", got1.size(), 14 + CK);
        for (int i = 0; i < 14; i++)
            if (i < got1.size()) chk($sformatf("small_b%0d", i), got1[i], exp1[i]);
`ifdef IMAGE_STREAM_TX_CHECKSUM_EN
        if (got1.size() > 14) chk("small_cksum", got1[14], 8'h00);
`endif
        chk("small_done", done1_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
